// File: rtl/video_encoder.sv
// ---------------------------------------------------------------------------
// video_encoder
//
// Converts the VIC-II pixel-rate outputs (4-bit luma, blank, hsync, vsync)
// into the 6-bit composite baseband level that the SSB modulator consumes on
// every clk. During the vertical interval it replaces hsync with broad pulses
// and serration gaps that are timed in clk cycles. The optional slew limiter
// bounds the level change per clk so that sharp edges do not spill energy past
// the modulator's 5 MHz filter.
//
// Optional feature macro: VIDEO_SLEW_LIMIT_EN
//   defined   : video moves toward the registered target by at most SLEW_STEP
//               per clk
//   undefined : video copies the registered target every clk
//
// Ports:
//   clk      in  1  modulator clock (141.8758 MHz)
//   reset    in  1  asynchronous reset, active low
//   pix_stb  in  1  one-cycle strobe; the pixel inputs are valid in that cycle
//   luma     in  4  pixel luminance code 0..15
//   blank    in  1  blanking, active high
//   hsync    in  1  horizontal sync, active high
//   vsync    in  1  vertical sync interval, active high
//   video    out 6  composite level to the modulator
//   csync    out 1  registered composite sync, active high
// ---------------------------------------------------------------------------
module video_encoder #(
   parameter int SYNC_LEVEL  = 0,
   parameter int BLANK_LEVEL = 15,
   parameter int BLACK_LEVEL = 18,
   parameter int LUMA_GAIN   = 3,
   parameter int SLEW_STEP   = 4,
   parameter int HALF_LINE   = 4540,
   parameter int SERR_CYCLES = 667
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_stb,
   input  logic [3:0] luma,
   input  logic       blank,
   input  logic       hsync,
   input  logic       vsync,
   output logic [5:0] video,
   output logic       csync
);

   localparam int CNT_W = $clog2(HALF_LINE);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HALF_LINE - 1);
   localparam logic [CNT_W-1:0] SERR_START = CNT_W'(HALF_LINE - SERR_CYCLES);
   localparam logic [5:0] SYNC_LVL  = 6'(SYNC_LEVEL);
   localparam logic [5:0] BLANK_LVL = 6'(BLANK_LEVEL);
   localparam logic [7:0] BLACK_LVL = 8'(BLACK_LEVEL);
   localparam logic [7:0] GAIN      = 8'(LUMA_GAIN);

   // A half line must hold a non-empty broad part and serration gap, and a
   // slew step must be able to make progress without exceeding the level range.
   if (SERR_CYCLES < 1 || SERR_CYCLES >= HALF_LINE || SLEW_STEP < 1 || SLEW_STEP > 63) begin : g_bad_params
      $error("video_encoder: illegal timing or slew parameters");
   end

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_BROAD,
      ST_SERR
   } vstate_t;

   logic [3:0]       luma_r;
   logic             blank_r;
   logic             hsync_r;
   logic             vsync_r;
   vstate_t          state;
   vstate_t          state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             csync_next;
   logic [7:0]       luma_sum;
   logic [5:0]       luma_lvl;
   logic [5:0]       target_r;
   logic [5:0]       target_next;

   // Pixel sample registers: they only move on a strobe, so between strobes
   // the encoder keeps working from the last pixel the VIC-II presented.
   // Reset leaves the line blanked and out of sync.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         luma_r  <= 4'd0;
         blank_r <= 1'b1;
         hsync_r <= 1'b0;
         vsync_r <= 1'b0;
      end else if (pix_stb) begin
         luma_r  <= luma;
         blank_r <= blank;
         hsync_r <= hsync;
         vsync_r <= vsync;
      end
   end

   // Half-line counter and vertical state. Entering the vertical interval
   // restarts the count at 0; while inside, the count runs free and wraps every
   // half line, and the broad/serration split falls out of where the count sits.
   // Leaving the interval clears the count at once, even mid half-line. The
   // composite sync and the target level are derived from the next state so
   // that they register on the same edge as the state itself.
   always_comb begin
      cnt_next    = '0;
      state_next  = ST_ACTIVE;
      csync_next  = hsync_r;
      luma_sum    = BLACK_LVL + GAIN * {4'd0, luma_r};
      luma_lvl    = (luma_sum > 8'd63) ? 6'd63 : luma_sum[5:0];
      target_next = BLANK_LVL;
      if (vsync_r) begin
         if (state != ST_ACTIVE && cnt != CNT_LAST) begin
            cnt_next = cnt + CNT_W'(1);
         end
         state_next = (cnt_next < SERR_START) ? ST_BROAD : ST_SERR;
      end
      case (state_next)
         ST_BROAD: csync_next = 1'b1;
         ST_SERR:  csync_next = 1'b0;
         default:  csync_next = hsync_r;
      endcase
      if (csync_next) begin
         target_next = SYNC_LVL;
      end else if (blank_r) begin
         target_next = BLANK_LVL;
      end else begin
         target_next = luma_lvl;
      end
   end

   // Vertical state machine with its registered outputs: state, counter,
   // composite sync and target level all move together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_ACTIVE;
         cnt      <= '0;
         csync    <= 1'b0;
         target_r <= BLANK_LVL;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         csync    <= csync_next;
         target_r <= target_next;
      end
   end

`ifdef VIDEO_SLEW_LIMIT_EN
   localparam logic signed [6:0] STEP_POS = 7'(SLEW_STEP);
   localparam logic signed [6:0] STEP_NEG = -STEP_POS;

   logic signed [6:0] diff;
   logic signed [6:0] step;
   logic signed [6:0] video_sum;

   // The step toward the target is clamped to +/-SLEW_STEP; when the remaining
   // distance is smaller the step is exactly that distance, so the output lands
   // on the target without overshooting and stays inside 0..63. Because the
   // distance is recomputed every clk, a new target redirects the ramp at once.
   always_comb begin
      diff = $signed({1'b0, target_r}) - $signed({1'b0, video});
      step = diff;
      if (diff > STEP_POS) begin
         step = STEP_POS;
      end else if (diff < STEP_NEG) begin
         step = STEP_NEG;
      end
      video_sum = $signed({1'b0, video}) + step;
   end

   // Output level register, ramping toward the target.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         video <= BLANK_LVL;
      end else begin
         video <= video_sum[5:0];
      end
   end
`else
   // Output level register: a straight copy of the target, one clk later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         video <= BLANK_LVL;
      end else begin
         video <= target_r;
      end
   end
`endif

endmodule
